// File: rtl/result_sender.sv
// Frames 32-bit results and work acknowledges into byte streams for a
// byte-wide transmitter. Results queue in a small FIFO. Acknowledges
// coalesce into one pending flag and go out ahead of queued results, but
// only at a frame boundary.
module result_sender #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] SYNC     = 8'hA5,
  parameter logic [7:0] T_RESULT = 8'h01,
  parameter logic [7:0] T_ACK    = 8'h02
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_result,
  input  logic [31:0]            result_data,
  input  logic                   got_work,
  input  logic                   tx_busy,
  output logic [7:0]             tx_data,
  output logic                   new_tx_data,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND   = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          ack_pend_q, ack_pend_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic          is_ack_q, is_ack_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          new_tx_data_q, new_tx_data_d;

  logic          pop, push, fifo_full, ack_clr;
  logic [7:0]    cur_byte, chk;
  logic [2:0]    last_idx;

  // FIFO bookkeeping. The pop only happens in IDLE when no ack is pending,
  // and a push at a full FIFO is still taken if that same edge pops.
  always_comb begin
    // NOTE: every combinational output gets a default value first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    pop        = (state_q == S_IDLE) && !ack_pend_q && (count_q != '0);
    fifo_full  = (count_q == FULL_CNT);
    push       = new_result && (!fifo_full || pop);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    overflow_d = overflow_q | (new_result & ~push);
  end

  // Select the byte at the current frame index from the frame register.
  always_comb begin
    chk      = T_RESULT ^ word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
    last_idx = is_ack_q ? 3'd2 : 3'd6;
    cur_byte = SYNC;
    case (idx_q)
      3'd0:    cur_byte = SYNC;
      3'd1:    cur_byte = is_ack_q ? T_ACK : T_RESULT;
      3'd2:    cur_byte = is_ack_q ? T_ACK : word_q[31:24];
      3'd3:    cur_byte = word_q[23:16];
      3'd4:    cur_byte = word_q[15:8];
      3'd5:    cur_byte = word_q[7:0];
      default: cur_byte = chk;
    endcase
  end

  // Frame sequencer: load a frame, then strobe one byte per transmitter handshake.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    word_d        = word_q;
    is_ack_d      = is_ack_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    ack_clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ack_pend_q) begin
          is_ack_d = 1'b1;
          ack_clr  = 1'b1;
          idx_d    = 3'd0;
          state_d  = S_SEND;
        end else if (count_q != '0) begin
          word_d   = mem[rd_ptr_q];
          is_ack_d = 1'b0;
          idx_d    = 3'd0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_data_d     = cur_byte;
          new_tx_data_d = 1'b1;
          state_d       = S_STROBE;
        end
      end
      S_STROBE: state_d = S_WAIT;
      S_WAIT: begin
        if (!tx_busy) begin
          if (idx_q == last_idx) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A got_work arriving on the same edge that consumes the flag re-arms it.
    ack_pend_d = got_work | (ack_pend_q & ~ack_clr);
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset. Emptiness is carried by the
    // pointers and the count, so stale contents are never read.
    if (push) mem[wr_ptr_q] <= result_data;
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments, so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      ack_pend_q    <= 1'b0;
      state_q       <= S_IDLE;
      idx_q         <= 3'd0;
      word_q        <= 32'h0;
      is_ack_q      <= 1'b0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      ack_pend_q    <= ack_pend_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      is_ack_q      <= is_ack_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;
  assign overflow    = overflow_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_result_sender.sv
// Self-checking bench for result_sender. A transmitter model collects every
// strobed byte. Each expected byte stream is built from the frame definitions.
module tb_result_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_result;
  logic [31:0] result_data;
  logic        got_work;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        overflow;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         busy_lo = 0, busy_hi = 0, busy_cnt = 0;
  logic       busy_hold = 1'b0;
  logic       prev_strobe = 1'b0;
  logic [7:0] last_tx = 8'h00;
  int         strobe_err = 0, hold_err = 0;

  result_sender #(.DEPTH(4), .SYNC(8'hA5), .T_RESULT(8'h01), .T_ACK(8'h02)) dut (
    .clk(clk), .rst(rst), .new_result(new_result), .result_data(result_data),
    .got_work(got_work), .tx_busy(tx_busy), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for a chosen number of cycles after each strobe.
  always @(negedge clk) begin
    if (!rst || busy_hold) begin
      busy_cnt = 0;
      tx_busy  = busy_hold;
    end else begin
      if (new_tx_data)       busy_cnt = $urandom_range(busy_hi, busy_lo);
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt != 0);
    end
  end

  // Byte collector and line-protocol watcher.
  always @(negedge clk) begin
    if (rst) begin
      if (new_tx_data) begin
        rx_q.push_back(tx_data);
        if (prev_strobe) strobe_err++;
      end else if (tx_data !== last_tx) begin
        hold_err++;
      end
    end
    prev_strobe = rst && new_tx_data;
    last_tx     = tx_data;
  end

  // Expected bytes of one result frame; the checksum covers type and data bytes.
  task automatic exp_result(input logic [31:0] w);
    logic [7:0] f[7];
    f[0] = 8'hA5; f[1] = 8'h01;
    f[2] = w[31:24]; f[3] = w[23:16]; f[4] = w[15:8]; f[5] = w[7:0];
    f[6] = 8'h00;
    for (int i = 1; i <= 5; i++) f[6] ^= f[i];
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  task automatic exp_ack();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'h02);
  endtask

  task automatic do_reset();
    rst = 1'b0; new_result = 1'b0; got_work = 1'b0; result_data = 32'h0;
    busy_hold = 1'b0;
    repeat (3) @(negedge clk);
    rx_q.delete(); exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_result(input logic [31:0] w);
    new_result = 1'b1; result_data = w;
    @(negedge clk);
    new_result = 1'b0;
  endtask

  task automatic pulse_work();
    got_work = 1'b1;
    @(negedge clk);
    got_work = 1'b0;
  endtask

  // Wait until n bytes arrived (bounded), then idle to catch any extra bytes.
  task automatic wait_bytes(input string name, input int n, input int budget);
    int cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rx_q.size() < n) begin
      failures++;
      $display("FAIL %s timeout: got %0d bytes, need %0d", name, rx_q.size(), n);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic compare_stream(input string name);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s length: got %0d, expected %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s byte %0d: got %02h, expected %02h", name, i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_outputs(input string name, input logic [7:0] e_tx, input logic e_stb,
                               input logic e_ovf, input logic [2:0] e_cnt);
    checks++;
    if (tx_data !== e_tx || new_tx_data !== e_stb || overflow !== e_ovf || fifo_count !== e_cnt) begin
      failures++;
      $display("FAIL %s: tx_data=%02h stb=%b ovf=%b cnt=%0d, expected %02h %b %b %0d",
               name, tx_data, new_tx_data, overflow, fifo_count, e_tx, e_stb, e_ovf, e_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; busy_hold = 1'b0; busy_lo = 0; busy_hi = 0;
    new_result = 1'b1; got_work = 1'b1; result_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check_outputs("reset_values", 8'h00, 1'b0, 1'b0, 3'd0);
    new_result = 1'b0; got_work = 1'b0;
    rx_q.delete(); exp_q.delete();
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_outputs("reset_strobes_ignored", 8'h00, 1'b0, 1'b0, 3'd0);
    compare_stream("reset_no_bytes");
  endtask

  task automatic test_latency();
    int lat;
    do_reset();
    busy_lo = 10; busy_hi = 10;
    new_result = 1'b1; result_data = 32'h12345678;
    lat = 0;
    @(negedge clk); lat++;
    new_result = 1'b0;
    while (!new_tx_data && lat < 20) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (lat != 3 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL first_strobe: cycle %0d data %02h, expected cycle 3 data a5", lat, tx_data);
    end
    exp_result(32'h12345678);
    wait_bytes("latency_frame", 7, 300);
    compare_stream("latency_frame");
  endtask

  task automatic test_ack_midframe();
    do_reset();
    busy_lo = 2; busy_hi = 2;
    pulse_result(32'hA1B2C3D4);
    pulse_result(32'h0BADF00D);
    pulse_result(32'hFFFF0000);
    for (int c = 0; c < 200 && rx_q.size() < 2; c++) @(negedge clk);
    pulse_work();
    repeat (3) @(negedge clk);
    pulse_work();
    exp_result(32'hA1B2C3D4); exp_ack();
    exp_result(32'h0BADF00D); exp_result(32'hFFFF0000);
    wait_bytes("ack_midframe", exp_q.size(), 1000);
    compare_stream("ack_midframe");
  endtask

  task automatic test_overflow();
    logic [31:0] w[6];
    do_reset();
    busy_lo = 1; busy_hi = 3;
    busy_hold = 1'b1;
    foreach (w[i]) w[i] = $urandom;
    foreach (w[i]) pulse_result(w[i]);
    @(negedge clk);
    check_outputs("overflow_held", 8'h00, 1'b0, 1'b1, 3'd4);
    busy_hold = 1'b0;
    for (int i = 0; i < 5; i++) exp_result(w[i]);
    wait_bytes("overflow_frames", 35, 2000);
    compare_stream("overflow_frames");
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL overflow_sticky: ovf=%b cnt=%0d, expected 1 0", overflow, fifo_count);
    end
  endtask

  // Fill the FIFO behind an ack frame, then push on the exact edge of the pop.
  task automatic test_full_pop();
    logic [31:0] w[5];
    int n;
    do_reset();
    busy_lo = 0; busy_hi = 0;
    busy_hold = 1'b1;
    foreach (w[i]) w[i] = $urandom;
    pulse_work();
    for (int i = 0; i < 4; i++) pulse_result(w[i]);
    @(negedge clk);
    check_outputs("full_before_pop", 8'h00, 1'b0, 1'b0, 3'd4);
    busy_hold = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      @(negedge clk);
      if (new_tx_data) n++;
    end
    // Last ack byte strobed; STROBE and WAIT take one cycle each, then IDLE pops.
    @(negedge clk);
    @(negedge clk);
    pulse_result(w[4]);
    checks++;
    if (overflow !== 1'b0 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL push_at_pop: ovf=%b cnt=%0d, expected 0 4", overflow, fifo_count);
    end
    exp_ack();
    foreach (w[i]) exp_result(w[i]);
    wait_bytes("full_pop_frames", exp_q.size(), 2000);
    compare_stream("full_pop_frames");
  endtask

  task automatic test_reset_midframe();
    do_reset();
    busy_lo = 3; busy_hi = 3;
    pulse_result(32'hCAFEF00D);
    pulse_result(32'h55AA55AA);
    for (int c = 0; c < 200 && rx_q.size() < 4; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("midframe_reset_values", 8'h00, 1'b0, 1'b0, 3'd0);
    repeat (3) @(negedge clk);
    rx_q.delete(); exp_q.delete();
    rst = 1'b1;
    repeat (60) @(negedge clk);
    compare_stream("after_reset_silent");
    pulse_result(32'h87654321);
    exp_result(32'h87654321);
    wait_bytes("after_reset_frame", 7, 300);
    compare_stream("after_reset_frame");
  endtask

  task automatic test_random();
    logic [31:0] w;
    int cyc;
    do_reset();
    busy_lo = 0; busy_hi = 4;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      cyc = 0;
      while (fifo_count == 3'd4 && cyc < 500) begin
        @(negedge clk); cyc++;
      end
      w = $urandom;
      exp_result(w);
      pulse_result(w);
    end
    wait_bytes("random_stream", 280, 20000);
    compare_stream("random_stream");
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL random_overflow: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (strobe_err != 0 || hold_err != 0) begin
      failures++;
      $display("FAIL line_protocol: back-to-back strobes %0d, tx_data changes %0d, expected 0 0",
               strobe_err, hold_err);
    end
  endtask

  initial begin
    rst = 1'b0; new_result = 1'b0; got_work = 1'b0; result_data = 32'h0; tx_busy = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_ack_midframe();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    test_random();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
